// File: rtl/spi_reg_bridge_if.sv
// Shifter-side and register-bus-side signals of spi_reg_bridge.
// master = the bridge's view; slave = the shifter/register-file side.
interface spi_reg_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic              tx_done;
  logic [DATA_W-1:0] tx_data;
  logic              tx_en;
  logic              wr_stb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    input  rx_data, rx_done, tx_done, rd_data,
    output tx_data, tx_en, wr_stb, wr_addr, wr_data, rd_req, rd_addr
  );

  modport slave (
    output rx_data, rx_done, tx_done, rd_data,
    input  tx_data, tx_en, wr_stb, wr_addr, wr_data, rd_req, rd_addr
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI frame decoder: command word + data words -> register writes/reads, read data back to the shifter.
// Optional aborted-read counter built only when SPI_REG_BRIDGE_ERRCNT_EN is defined.
module spi_reg_bridge #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_cs,
  spi_reg_bridge_if.master     bus,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_REQ   = 3'd2,
    RD_WAIT  = 3'd3,
    RD_SHIFT = 3'd4,
    RD_HOLD  = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        cs_sync_q, cs_sync_d;
  logic              settle_q, settle_d;
  logic              armed_q, armed_d;
  logic              rx_vld_q, rx_vld_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              inc_q, inc_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              cs_s;
  logic              word_s;

  assign cs_s = cs_sync_q[1];

  // Synchroniser, word-valid pipeline and frame arming; a frame is only
  // accepted once the raw pin has been seen high after reset.
  always_comb begin
    cs_sync_d = {cs_sync_q[0], spi_cs};
    settle_d  = 1'b1;
    rx_vld_d  = bus.rx_done;
    if (settle_q && cs_sync_q[0]) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    word_s = rx_vld_q & armed_q;
  end

  // Frame state machine: next state and registered-output values.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    inc_d     = inc_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    if (cs_s) begin
      state_d = IDLE;
      ptr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (word_s) begin
            ptr_d = bus.rx_data[ADDR_W-1:0];
            inc_d = bus.rx_data[DATA_W-2];
            if (bus.rx_data[DATA_W-1]) begin
              state_d   = RD_REQ;
              rd_req_d  = 1'b1;
              rd_addr_d = bus.rx_data[ADDR_W-1:0];
            end else begin
              state_d = WR;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WR: begin
          if (word_s) begin
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = bus.rx_data;
            if (inc_q) begin
              ptr_d = ptr_q + PTR_ONE;
            end else begin
              ptr_d = ptr_q;
            end
          end else begin
            state_d = WR;
          end
        end
        RD_REQ: begin
          state_d = RD_WAIT;
        end
        RD_WAIT: begin
          tx_data_d = bus.rd_data;
          tx_en_d   = 1'b1;
          state_d   = RD_SHIFT;
        end
        RD_SHIFT: begin
          // tx_done takes priority; any word arriving here is a dummy.
          if (bus.tx_done) begin
            if (inc_q) begin
              ptr_d     = ptr_q + PTR_ONE;
              rd_addr_d = ptr_q + PTR_ONE;
              rd_req_d  = 1'b1;
              state_d   = RD_REQ;
            end else begin
              state_d = RD_HOLD;
            end
          end else begin
            state_d = RD_SHIFT;
          end
        end
        RD_HOLD: begin
          state_d = RD_HOLD;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cs_sync_q <= 2'b11;
      settle_q  <= 1'b0;
      armed_q   <= 1'b0;
      rx_vld_q  <= 1'b0;
      ptr_q     <= '0;
      inc_q     <= 1'b0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_sync_q <= cs_sync_d;
      settle_q  <= settle_d;
      armed_q   <= armed_d;
      rx_vld_q  <= rx_vld_d;
      ptr_q     <= ptr_d;
      inc_q     <= inc_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign busy        = busy_q;

`ifdef SPI_REG_BRIDGE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       rd_active_s;

  // Saturating count of reads cut off by chip-select before tx_done.
  always_comb begin
    rd_active_s = (state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == RD_SHIFT);
    if (cs_s && rd_active_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: stimulus pushes expected bus events, a negedge monitor pops and compares.
module tb_spi_reg_bridge;

  localparam int GAP = 10;
`ifdef SPI_REG_BRIDGE_ERRCNT_EN
  localparam int ERR_INC = 1;
`else
  localparam int ERR_INC = 0;
`endif

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs;
  logic       busy;
  logic [7:0] err_cnt;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         err_exp = 0;
  logic [15:0] mem [16];
  ev_t exp_wr[$];
  ev_t exp_rd[$];
  ev_t exp_tx[$];
  ev_t mon_e;

  spi_reg_bridge_if #(.DATA_W(16), .ADDR_W(4)) bus_if ();

  spi_reg_bridge #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi_cs  (spi_cs),
    .bus     (bus_if.master),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: one-cycle read latency
  always @(posedge clk) if (bus_if.rd_req) bus_if.rd_data <= mem[bus_if.rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push(inout ev_t q[$], input logic [3:0] a, input logic [15:0] d, input int c);
    ev_t e;
    e.addr = a; e.data = d; e.cyc = c;
    q.push_back(e);
  endtask

  // Monitor: every DUT event must match the head of its queue, including cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus_if.wr_stb === 1'b1) begin
        if (exp_wr.size() == 0) chk("wr_stb_unexpected", 32'(bus_if.wr_stb), 32'd0);
        else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus_if.wr_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(bus_if.wr_data), 32'(mon_e.data));
          chk("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (bus_if.rd_req === 1'b1) begin
        if (exp_rd.size() == 0) chk("rd_req_unexpected", 32'(bus_if.rd_req), 32'd0);
        else begin
          mon_e = exp_rd.pop_front();
          chk("rd_addr", 32'(bus_if.rd_addr), 32'(mon_e.addr));
          chk("rd_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      if (bus_if.tx_en === 1'b1) begin
        if (exp_tx.size() == 0) chk("tx_en_unexpected", 32'(bus_if.tx_en), 32'd0);
        else begin
          mon_e = exp_tx.pop_front();
          chk("tx_data", 32'(bus_if.tx_data), 32'(mon_e.data));
          chk("tx_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  // All tasks start and end #1 after a rising edge
  task automatic drive_word(input logic [15:0] w, input logic td);
    bus_if.rx_data = w;
    bus_if.rx_done = 1'b1;
    bus_if.tx_done = td;
    @(posedge clk); #1;
    bus_if.rx_done = 1'b0;
    bus_if.tx_done = 1'b0;
    repeat (GAP) @(posedge clk);
    #1;
  endtask

  task automatic cs_set(input logic v);
    spi_cs = v;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx_data"}, 32'(bus_if.tx_data), 32'd0);
    chk({tag, "_tx_en"},   32'(bus_if.tx_en),   32'd0);
    chk({tag, "_wr_stb"},  32'(bus_if.wr_stb),  32'd0);
    chk({tag, "_wr_addr"}, 32'(bus_if.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus_if.wr_data), 32'd0);
    chk({tag, "_rd_req"},  32'(bus_if.rd_req),  32'd0);
    chk({tag, "_rd_addr"}, 32'(bus_if.rd_addr), 32'd0);
    chk({tag, "_busy"},    32'(busy),           32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt),        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    mem[2] = 16'h2C2C;
    mem[3] = 16'h3D3D;
    mem[4] = 16'h4E4E;
    mem[5] = 16'hA5C3;
    mem[6] = 16'h6666;
    bus_if.rd_data = 16'h0000;
    bus_if.rx_data = 16'h0000;
    bus_if.rx_done = 1'b0;
    bus_if.tx_done = 1'b0;
    spi_cs = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1;

    // Single write
    cs_set(1'b0);
    drive_word(16'h0003, 1'b0);
    chk("busy_after_cmd", 32'(busy), 32'd1);
    push(exp_wr, 4'd3, 16'hBEEF, cyc + 2);
    drive_word(16'hBEEF, 1'b0);
    cs_set(1'b1);
    chk("busy_after_cs", 32'(busy), 32'd0);

    // Burst write with wrap 14, 15, 0
    cs_set(1'b0);
    drive_word(16'h400E, 1'b0);
    push(exp_wr, 4'd14, 16'h1111, cyc + 2);
    drive_word(16'h1111, 1'b0);
    push(exp_wr, 4'd15, 16'h2222, cyc + 2);
    drive_word(16'h2222, 1'b0);
    push(exp_wr, 4'd0, 16'h3333, cyc + 2);
    drive_word(16'h3333, 1'b0);
    cs_set(1'b1);

    // Single read; the dummy word's tx_done ends the read, later words are ignored
    cs_set(1'b0);
    push(exp_rd, 4'd5, 16'h0000, cyc + 2);
    push(exp_tx, 4'd5, 16'hA5C3, cyc + 4);
    drive_word(16'h8005, 1'b0);
    drive_word(16'h0000, 1'b1);
    drive_word(16'hFFFF, 1'b0);
    cs_set(1'b1);
    chk("err_after_single_read", 32'(err_cnt), 32'(err_exp));

    // Abort in RD_SHIFT
    cs_set(1'b0);
    push(exp_rd, 4'd6, 16'h0000, cyc + 2);
    push(exp_tx, 4'd6, 16'h6666, cyc + 4);
    drive_word(16'h8006, 1'b0);
    chk("busy_in_rd_shift", 32'(busy), 32'd1);
    cs_set(1'b1);
    err_exp += ERR_INC;
    chk("busy_after_abort", 32'(busy), 32'd0);
    chk("err_after_abort", 32'(err_cnt), 32'(err_exp));
    chk("tx_data_held", 32'(bus_if.tx_data), 32'h6666);
    cs_set(1'b0);
    drive_word(16'h0001, 1'b0);
    push(exp_wr, 4'd1, 16'h0042, cyc + 2);
    drive_word(16'h0042, 1'b0);
    cs_set(1'b1);

    // Burst read 2, 3, 4; tx_done coincides with dummy words, frame cut before the third tx_done
    cs_set(1'b0);
    push(exp_rd, 4'd2, 16'h0000, cyc + 2);
    push(exp_tx, 4'd2, 16'h2C2C, cyc + 4);
    drive_word(16'hC002, 1'b0);
    push(exp_rd, 4'd3, 16'h0000, cyc + 1);
    push(exp_tx, 4'd3, 16'h3D3D, cyc + 3);
    drive_word(16'h0000, 1'b1);
    push(exp_rd, 4'd4, 16'h0000, cyc + 1);
    push(exp_tx, 4'd4, 16'h4E4E, cyc + 3);
    drive_word(16'h0000, 1'b1);
    drive_word(16'h0000, 1'b0);
    cs_set(1'b1);
    err_exp += ERR_INC;
    chk("err_after_burst_abort", 32'(err_cnt), 32'(err_exp));

    // Reset in the middle of a write frame
    cs_set(1'b0);
    drive_word(16'h0007, 1'b0);
    push(exp_wr, 4'd7, 16'h1234, cyc + 2);
    drive_word(16'h1234, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    err_exp = 0;
    check_idle_outputs("midreset");
    drive_word(16'h0003, 1'b0);
    drive_word(16'h5555, 1'b0);
    chk("busy_unarmed", 32'(busy), 32'd0);
    cs_set(1'b1);
    cs_set(1'b0);
    drive_word(16'h000A, 1'b0);
    push(exp_wr, 4'd10, 16'h00AA, cyc + 2);
    drive_word(16'h00AA, 1'b0);
    cs_set(1'b1);

    repeat (4) @(posedge clk);
    #1;
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    chk("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
